// File: rtl/simd_gpu_core.sv
// SIMD execution core: one instruction runs in lock-step across NUM_LANES lanes, each with a
// private register file, gated by a per-instruction lane mask and valid/ready handshakes.
module simd_gpu_core #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_REGS  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  input  logic [31:0]                   instr,
  input  logic [NUM_LANES-1:0]          lane_mask,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [NUM_LANES*DATA_W-1:0]   result_data,
  output logic [NUM_LANES-1:0]          result_mask,
  output logic                          illegal
);

  localparam int unsigned RegAw = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned ShAw  = $clog2(DATA_W);

  localparam logic [3:0] OpAdd    = 4'd0;
  localparam logic [3:0] OpSub    = 4'd1;
  localparam logic [3:0] OpMul    = 4'd2;
  localparam logic [3:0] OpAnd    = 4'd3;
  localparam logic [3:0] OpOr     = 4'd4;
  localparam logic [3:0] OpXor    = 4'd5;
  localparam logic [3:0] OpShl    = 4'd6;
  localparam logic [3:0] OpShr    = 4'd7;
  localparam logic [3:0] OpAddi   = 4'd8;
  localparam logic [3:0] OpLi     = 4'd9;
  localparam logic [3:0] OpLaneId = 4'd10;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q, state_d;

  logic [31:0]                                   instr_q;
  logic [NUM_LANES-1:0]                          mask_q;
  logic [NUM_LANES-1:0][NUM_REGS-1:0][DATA_W-1:0] rf_q;
  logic [NUM_LANES-1:0][DATA_W-1:0]              lane_res;
  logic [NUM_LANES-1:0][DATA_W-1:0]              data_d, data_q;
  logic [NUM_LANES-1:0]                          rmask_q;
  logic                                          illegal_q;

  logic [3:0]        op;
  logic [RegAw-1:0]  rd, rs1, rs2;
  logic [DATA_W-1:0] imm_ext, op_a, op_b;
  logic              legal;
  logic              accept;

  assign instr_ready  = (state_q == StIdle);
  assign result_valid = (state_q == StResp);
  assign accept       = instr_valid & instr_ready;
  assign result_data  = data_q;
  assign result_mask  = rmask_q;
  assign illegal      = illegal_q;

  assign op      = instr_q[31:28];
  assign rd      = instr_q[23 +: RegAw];
  assign rs1     = instr_q[18 +: RegAw];
  assign rs2     = instr_q[13 +: RegAw];
  assign imm_ext = DATA_W'($signed(instr_q[12:0]));
  assign legal   = (op <= OpLaneId);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (instr_valid) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (result_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operands are read from the pre-write register state, so rd may alias rs1/rs2.
  always_comb begin
    lane_res = '0;
    data_d   = '0;
    op_a     = '0;
    op_b     = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      op_a = rf_q[l][rs1];
      op_b = rf_q[l][rs2];
      case (op)
        OpAdd:    lane_res[l] = op_a + op_b;
        OpSub:    lane_res[l] = op_a - op_b;
        OpMul:    lane_res[l] = op_a * op_b;
        OpAnd:    lane_res[l] = op_a & op_b;
        OpOr:     lane_res[l] = op_a | op_b;
        OpXor:    lane_res[l] = op_a ^ op_b;
        OpShl:    lane_res[l] = op_a << op_b[ShAw-1:0];
        OpShr:    lane_res[l] = op_a >> op_b[ShAw-1:0];
        OpAddi:   lane_res[l] = op_a + imm_ext;
        OpLi:     lane_res[l] = imm_ext;
        OpLaneId: lane_res[l] = DATA_W'(l);
        default:  lane_res[l] = '0;
      endcase
      if (mask_q[l] && legal) data_d[l] = lane_res[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      rmask_q   <= '0;
      illegal_q <= 1'b0;
      rf_q      <= '0;
    end else begin
      if (accept) begin
        instr_q <= instr;
        mask_q  <= lane_mask;
      end
      if (state_q == StExec) begin
        data_q    <= data_d;
        rmask_q   <= mask_q;
        illegal_q <= ~legal;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
          if (mask_q[l] && legal) rf_q[l][rd] <= lane_res[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_simd_gpu_core.sv
// Directed self-checking bench for simd_gpu_core (4 lanes x 32 bits, 32 registers).
module tb_simd_gpu_core;

  logic         clk;
  logic         rst_n;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [3:0]   lane_mask;
  logic         result_valid;
  logic         result_ready;
  logic [127:0] result_data;
  logic [3:0]   result_mask;
  logic         illegal;

  int n_tests = 0;
  int n_fail  = 0;

  simd_gpu_core #(
    .NUM_LANES(4),
    .DATA_W   (32),
    .NUM_REGS (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .lane_mask   (lane_mask),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_data (result_data),
    .result_mask (result_mask),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] lanes(input logic [31:0] l3, input logic [31:0] l2,
                                         input logic [31:0] l1, input logic [31:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  // Drive at a negedge; returns at the negedge after the accept edge (core in EXEC).
  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [12:0] imm, input logic [3:0] mask);
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 128'(instr_ready), 128'd1);
    instr       = {op, rd, rs1, rs2, imm};
    lane_mask   = mask;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [127:0] exp_data,
                            input logic [3:0] exp_mask, input logic exp_ill);
    check({tag, "_exec_valid"}, 128'(result_valid), 128'd0);
    @(negedge clk);
    check({tag, "_valid"}, 128'(result_valid), 128'd1);
    check({tag, "_data"}, result_data, exp_data);
    check({tag, "_mask"}, 128'(result_mask), 128'(exp_mask));
    check({tag, "_illegal"}, 128'(illegal), 128'(exp_ill));
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check({tag, "_ready_after"}, 128'(instr_ready), 128'd1);
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                       input logic [3:0] mask, input logic [127:0] exp_data,
                       input logic [3:0] exp_mask, input logic exp_ill);
    send(op, rd, rs1, rs2, imm, mask);
    get_result(tag, exp_data, exp_mask, exp_ill);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] held;
    rst_n        = 1'b0;
    instr_valid  = 1'b0;
    instr        = '0;
    lane_mask    = '0;
    result_ready = 1'b0;

    // T1: reset state and a zero add
    do_reset();
    check("rst_ready", 128'(instr_ready), 128'd1);
    check("rst_valid", 128'(result_valid), 128'd0);
    check("rst_data", result_data, 128'd0);
    check("rst_mask", 128'(result_mask), 128'd0);
    check("rst_illegal", 128'(illegal), 128'd0);
    do_op("add0", 4'd0, 5'd1, 5'd0, 5'd0, 13'd0, 4'hF, 128'd0, 4'hF, 1'b0);

    // T2: lane id and add-immediate
    do_op("laneid", 4'd10, 5'd1, 5'd0, 5'd0, 13'd0, 4'hF, lanes(3, 2, 1, 0), 4'hF, 1'b0);
    do_op("addi", 4'd8, 5'd2, 5'd1, 5'd0, 13'd5, 4'hF, lanes(8, 7, 6, 5), 4'hF, 1'b0);

    // T3: masked load of -1, then read back through all lanes
    do_op("li_m", 4'd9, 5'd3, 5'd0, 5'd0, 13'h1FFF, 4'b0101,
          lanes(0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF), 4'b0101, 1'b0);
    do_op("add_m", 4'd0, 5'd4, 5'd3, 5'd0, 13'd0, 4'hF,
          lanes(0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF), 4'hF, 1'b0);

    // T4: backpressure; a competing instruction must not be accepted
    send(4'd4, 5'd8, 5'd1, 5'd2, 13'd0, 4'hF);
    @(negedge clk);
    held = lanes(11, 7, 7, 5);
    check("bp_or_data", result_data, held);
    instr       = {4'd5, 5'd9, 5'd1, 5'd2, 13'd0};
    lane_mask   = 4'hF;
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 128'(result_valid), 128'd1);
      check("bp_ready", 128'(instr_ready), 128'd0);
      check("bp_held", result_data, held);
    end
    instr_valid  = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("bp_drain", 128'(result_valid), 128'd0);
    do_op("bp_noacc", 4'd0, 5'd10, 5'd9, 5'd0, 13'd0, 4'hF, 128'd0, 4'hF, 1'b0);

    // T5: wrap, shifts with rd==rs, multiply overflow
    do_op("li1", 4'd9, 5'd5, 5'd0, 5'd0, 13'd1, 4'hF, lanes(1, 1, 1, 1), 4'hF, 1'b0);
    do_op("sub_wrap", 4'd1, 5'd6, 5'd0, 5'd5, 13'd0, 4'hF, {4{32'hFFFF_FFFF}}, 4'hF, 1'b0);
    do_op("li2048", 4'd9, 5'd7, 5'd0, 5'd0, 13'd2048, 4'hF, {4{32'd2048}}, 4'hF, 1'b0);
    do_op("shl_mod", 4'd6, 5'd7, 5'd7, 5'd7, 13'd0, 4'hF, {4{32'd2048}}, 4'hF, 1'b0);
    do_op("li5", 4'd9, 5'd12, 5'd0, 5'd0, 13'd5, 4'hF, {4{32'd5}}, 4'hF, 1'b0);
    do_op("shl5", 4'd6, 5'd7, 5'd7, 5'd12, 13'd0, 4'hF, {4{32'h0001_0000}}, 4'hF, 1'b0);
    do_op("mul_ovf", 4'd2, 5'd13, 5'd7, 5'd7, 13'd0, 4'hF, 128'd0, 4'hF, 1'b0);
    do_op("shr5", 4'd7, 5'd14, 5'd7, 5'd12, 13'd0, 4'hF, {4{32'h0000_0800}}, 4'hF, 1'b0);
    do_op("and", 4'd3, 5'd15, 5'd2, 5'd1, 13'd0, 4'hF, lanes(0, 2, 0, 0), 4'hF, 1'b0);
    do_op("xor", 4'd5, 5'd20, 5'd1, 5'd2, 13'd0, 4'hF, lanes(11, 5, 7, 5), 4'hF, 1'b0);

    // T6: illegal opcode, empty mask, reset mid-flight
    do_op("illegal", 4'hF, 5'd1, 5'd1, 5'd1, 13'd7, 4'hF, 128'd0, 4'hF, 1'b1);
    do_op("mask0", 4'd9, 5'd1, 5'd0, 5'd0, 13'd7, 4'h0, 128'd0, 4'h0, 1'b0);
    do_op("r1_kept", 4'd0, 5'd16, 5'd1, 5'd0, 13'd0, 4'hF, lanes(3, 2, 1, 0), 4'hF, 1'b0);

    send(4'd9, 5'd17, 5'd0, 5'd0, 13'd100, 4'hF);
    rst_n = 1'b0;
    #1;
    check("rst_exec_valid", 128'(result_valid), 128'd0);
    check("rst_exec_ready", 128'(instr_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("rf_clear17", 4'd0, 5'd18, 5'd17, 5'd0, 13'd0, 4'hF, 128'd0, 4'hF, 1'b0);
    do_op("rf_clear12", 4'd0, 5'd19, 5'd1, 5'd2, 13'd0, 4'hF, 128'd0, 4'hF, 1'b0);

    send(4'd9, 5'd21, 5'd0, 5'd0, 13'd9, 4'hF);
    @(negedge clk);
    check("resp_valid", 128'(result_valid), 128'd1);
    rst_n = 1'b0;
    #1;
    check("rst_resp_valid", 128'(result_valid), 128'd0);
    check("rst_resp_data", result_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
